// File: rtl/wb_retire_queue_pkg.sv
// Shared writeback definitions: default register-file widths, entry layout and
// the hard-wired zero register index.
package wb_retire_queue_pkg;

  localparam int WB_DATA_W  = 16;
  localparam int WB_RADDR_W = 4;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_retire_queue_fwd_match.sv
// Youngest-match bypass search over the pending-write ring, scanned from the
// head (oldest) so that later matches override earlier ones.
module wb_fwd_match
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W,
  parameter int DEPTH   = 4
) (
  input  logic [RADDR_W-1:0]       ent_addr [DEPTH],
  input  logic [DATA_W-1:0]        ent_data [DEPTH],
  input  logic [DEPTH-1:0]         ent_vld,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [RADDR_W-1:0]       raddr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  localparam int PTR_W = $clog2(DEPTH);

  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_vld[idx] && (ent_addr[idx] == raddr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Two-source in-order writeback queue draining into the register-file write
// port, with pending-write bypass and a one-cycle retire pulse.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W,
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     MEM_VALID,
  input  logic [RADDR_W-1:0]       MEM_ADDR,
  input  logic [DATA_W-1:0]        MEM_DATA,
  input  logic                     ALU_VALID,
  input  logic [RADDR_W-1:0]       ALU_ADDR,
  input  logic [DATA_W-1:0]        ALU_DATA,
  output logic                     IN_READY,
  output logic                     RF_WE,
  output logic [RADDR_W-1:0]       RF_WADDR,
  output logic [DATA_W-1:0]        RF_WDATA,
  input  logic                     RF_READY,
  input  logic [RADDR_W-1:0]       FWD_RADDR,
  output logic                     FWD_HIT,
  output logic [DATA_W-1:0]        FWD_DATA,
  output logic                     RET_VALID,
  output logic [RADDR_W-1:0]       RET_REG,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0]  ent_data [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   alu_slot;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   occ;
  logic               mem_acc;
  logic               alu_acc;
  logic               commit;
  logic               ret_vld_p1;
  logic [RADDR_W-1:0] ret_reg_p1;

  function automatic logic keep_req(input logic vld, input logic [RADDR_W-1:0] addr);
    return vld && !(DROP_R0 && (addr == RADDR_W'(ZERO_REG)));
  endfunction

  assign IN_READY = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign mem_acc  = IN_READY && keep_req(MEM_VALID, MEM_ADDR);
  assign alu_acc  = IN_READY && keep_req(ALU_VALID, ALU_ADDR);
  assign RF_WE    = (count != '0);
  assign RF_WADDR = ent_addr[head];
  assign RF_WDATA = ent_data[head];
  assign commit   = RF_WE && RF_READY;
  // MEM is the older instruction, so ALU lands one slot behind it.
  assign alu_slot = tail + PTR_W'(mem_acc);

  always_comb begin
    logic [PTR_W-1:0] rel;
    occ = '0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel    = PTR_W'(i) - head;
      occ[i] = {1'b0, rel} < count;
    end
  end

  // Stage p0: queue control and retire pulse register
  always_ff @(posedge CLK) begin
    if (RST) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ret_vld_p1 <= 1'b0;
      ret_reg_p1 <= '0;
    end else begin
      if (commit) begin
        head       <= head + PTR_W'(1);
        ret_reg_p1 <= ent_addr[head];
      end
      tail       <= tail + PTR_W'(mem_acc) + PTR_W'(alu_acc);
      count      <= count + CNT_W'(mem_acc) + CNT_W'(alu_acc) - CNT_W'(commit);
      ret_vld_p1 <= commit;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_acc) begin
      ent_addr[tail] <= MEM_ADDR;
      ent_data[tail] <= MEM_DATA;
    end
    if (alu_acc) begin
      ent_addr[alu_slot] <= ALU_ADDR;
      ent_data[alu_slot] <= ALU_DATA;
    end
  end

  wb_fwd_match #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .DEPTH   (DEPTH)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (occ),
    .head     (head),
    .raddr    (FWD_RADDR),
    .hit      (FWD_HIT),
    .data     (FWD_DATA)
  );

  assign RET_VALID = ret_vld_p1;
  assign RET_REG   = ret_reg_p1;
  assign COUNT     = count;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_wb_retire_queue;
  import wb_retire_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        MEM_VALID;
  logic [3:0]  MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic        ALU_VALID;
  logic [3:0]  ALU_ADDR;
  logic [15:0] ALU_DATA;
  logic        IN_READY;
  logic        RF_WE;
  logic [3:0]  RF_WADDR;
  logic [15:0] RF_WDATA;
  logic        RF_READY;
  logic [3:0]  FWD_RADDR;
  logic        FWD_HIT;
  logic [15:0] FWD_DATA;
  logic        RET_VALID;
  logic [3:0]  RET_REG;
  logic [2:0]  COUNT;

  wb_retire_queue #(.DATA_W(16), .RADDR_W(4), .DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .IN_READY(IN_READY), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .RF_READY(RF_READY), .FWD_RADDR(FWD_RADDR), .FWD_HIT(FWD_HIT), .FWD_DATA(FWD_DATA),
    .RET_VALID(RET_VALID), .RET_REG(RET_REG), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  wb_entry_t   exp_q[$];
  logic        m_ret;
  logic [3:0]  m_retreg;

  typedef struct {
    logic rst; logic mv; logic [3:0] ma; logic [15:0] md;
    logic av; logic [3:0] aa; logic [15:0] ad; logic rdy; logic [3:0] fa;
    logic we; logic [3:0] wa; logic [15:0] wd; logic hit; logic [15:0] fd;
    logic ret; logic [3:0] rr; logic [2:0] cnt; logic ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(int rst, int mv, int ma, int md, int av, int aa, int ad,
                               int rdy, int fa, int we, int wa, int wd, int hit, int fd,
                               int ret, int rr, int cnt, int ir);
    vec_t v;
    v.rst = 1'(rst); v.mv = 1'(mv); v.ma = 4'(ma); v.md = 16'(md);
    v.av = 1'(av); v.aa = 4'(aa); v.ad = 16'(ad); v.rdy = 1'(rdy); v.fa = 4'(fa);
    v.we = 1'(we); v.wa = 4'(wa); v.wd = 16'(wd); v.hit = 1'(hit); v.fd = 16'(fd);
    v.ret = 1'(ret); v.rr = 4'(rr); v.cnt = 3'(cnt); v.ir = 1'(ir);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
  endtask

  task automatic set_idle();
    RST = 1'b0; MEM_VALID = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;
    ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0; RF_READY = 1'b0; FWD_RADDR = '0;
  endtask

  function automatic bit model_ready();
    return (DEPTH - exp_q.size()) >= 2;
  endfunction

  task automatic model_edge();
    bit ok;
    bit com;
    if (RST) begin
      exp_q.delete();
      m_ret    = 1'b0;
      m_retreg = '0;
    end else begin
      ok  = model_ready();
      com = (exp_q.size() != 0) && RF_READY;
      if (com) begin
        m_retreg = exp_q[0].addr;
        void'(exp_q.pop_front());
      end
      m_ret = com;
      if (ok && MEM_VALID && MEM_ADDR != 4'd0) exp_q.push_back('{addr: MEM_ADDR, data: MEM_DATA});
      if (ok && ALU_VALID && ALU_ADDR != 4'd0) exp_q.push_back('{addr: ALU_ADDR, data: ALU_DATA});
    end
  endtask

  task automatic check_model();
    logic        e_hit;
    logic [15:0] e_fd;
    e_hit = 1'b0;
    e_fd  = '0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].addr == FWD_RADDR) begin e_hit = 1'b1; e_fd = exp_q[i].data; end
    chk("count", 32'(COUNT), exp_q.size());
    chk("in_ready", 32'(IN_READY), 32'(model_ready()));
    chk("rf_we", 32'(RF_WE), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("rf_waddr", 32'(RF_WADDR), 32'(exp_q[0].addr));
      chk("rf_wdata", 32'(RF_WDATA), 32'(exp_q[0].data));
    end
    chk("fwd_hit", 32'(FWD_HIT), 32'(e_hit));
    chk("fwd_data", 32'(FWD_DATA), 32'(e_fd));
    chk("ret_valid", 32'(RET_VALID), 32'(m_ret));
    chk("ret_reg", 32'(RET_REG), 32'(m_retreg));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
  endtask

  initial begin
    int issued;
    int drained;
    set_idle();
    RST = 1'b1;
    @(negedge CLK);

    // rst mv ma md av aa ad rdy fa | we wa wd hit fd ret rr cnt ir
    vecs.push_back(mkv(1,0,0,0,      0,0,0,      0,0, 0,0,0,      0,0,      0,0,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      0,3, 0,0,0,      0,0,      0,0,0,1));
    vecs.push_back(mkv(0,0,0,0,      1,3,'h1234, 1,3, 0,0,0,      0,0,      0,0,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,3, 1,3,'h1234, 1,'h1234, 0,0,1,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,3, 0,0,0,      0,0,      1,3,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      0,3, 0,0,0,      0,0,      0,3,0,1));
    vecs.push_back(mkv(0,1,5,'hAAAA, 1,5,'hBBBB, 0,5, 0,0,0,      0,0,      0,3,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      0,5, 1,5,'hAAAA, 1,'hBBBB, 0,3,2,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,5, 1,5,'hAAAA, 1,'hBBBB, 0,3,2,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,5, 1,5,'hBBBB, 1,'hBBBB, 1,5,1,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,5, 0,0,0,      0,0,      1,5,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      0,5, 0,0,0,      0,0,      0,5,0,1));
    vecs.push_back(mkv(0,0,0,0,      1,0,'hFFFF, 1,0, 0,0,0,      0,0,      0,5,0,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,0, 0,0,0,      0,0,      0,5,0,1));
    vecs.push_back(mkv(0,1,1,'h0101, 1,2,'h0202, 0,1, 0,0,0,      0,0,      0,5,0,1));
    vecs.push_back(mkv(0,0,0,0,      1,3,'h0303, 1,1, 1,1,'h0101, 1,'h0101, 0,5,2,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      0,3, 1,2,'h0202, 1,'h0303, 1,1,2,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,2, 1,2,'h0202, 1,'h0202, 0,1,2,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,2, 1,3,'h0303, 0,0,      1,2,1,1));
    vecs.push_back(mkv(0,0,0,0,      0,0,0,      1,3, 0,0,0,      0,0,      1,3,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst; MEM_VALID = vecs[i].mv; MEM_ADDR = vecs[i].ma; MEM_DATA = vecs[i].md;
      ALU_VALID = vecs[i].av; ALU_ADDR = vecs[i].aa; ALU_DATA = vecs[i].ad;
      RF_READY = vecs[i].rdy; FWD_RADDR = vecs[i].fa;
      #1;
      if (i > 0) begin
        chk("vec_rf_we", 32'(RF_WE), 32'(vecs[i].we));
        if (vecs[i].we) begin
          chk("vec_rf_waddr", 32'(RF_WADDR), 32'(vecs[i].wa));
          chk("vec_rf_wdata", 32'(RF_WDATA), 32'(vecs[i].wd));
        end
        chk("vec_fwd_hit", 32'(FWD_HIT), 32'(vecs[i].hit));
        chk("vec_fwd_data", 32'(FWD_DATA), 32'(vecs[i].fd));
        chk("vec_ret_valid", 32'(RET_VALID), 32'(vecs[i].ret));
        chk("vec_ret_reg", 32'(RET_REG), 32'(vecs[i].rr));
        chk("vec_count", 32'(COUNT), 32'(vecs[i].cnt));
        chk("vec_in_ready", 32'(IN_READY), 32'(vecs[i].ir));
      end
      step();
    end

    // Backpressure: fill under stall, then drain ten writes through the ring.
    set_idle();
    RST = 1'b1;
    step();
    issued  = 0;
    drained = 0;
    for (int c = 0; c < 60 && drained < 10; c++) begin
      set_idle();
      RF_READY  = (issued >= 3) && (c >= 5);
      FWD_RADDR = 4'(c % 11 + 1);
      if (issued < 10 && model_ready()) begin
        ALU_VALID = 1'b1;
        ALU_ADDR  = 4'(issued % 11 + 1);
        ALU_DATA  = 16'(16'h0100 + issued);
        issued++;
      end
      #1;
      if (exp_q.size() == 3) chk("bp_full_in_ready", 32'(IN_READY), 0);
      if (RF_WE && RF_READY) begin
        chk("bp_drain_order", 32'(RF_WDATA), 32'h0100 + drained);
        drained++;
      end
      check_model();
      step();
    end
    chk("bp_drain_total", drained, 10);

    // Reset while three entries are pending and the RF is ready.
    set_idle();
    for (int k = 0; k < 3; k++) begin
      MEM_VALID = 1'b1;
      MEM_ADDR  = 4'(7 + k);
      MEM_DATA  = 16'(16'h0700 + k);
      #1;
      check_model();
      step();
    end
    set_idle();
    RST = 1'b1; RF_READY = 1'b1; FWD_RADDR = 4'd7;
    #1;
    chk("rst_pre_count", 32'(COUNT), 3);
    check_model();
    step();
    set_idle();
    RF_READY = 1'b1; FWD_RADDR = 4'd7;
    #1;
    chk("rst_rf_we", 32'(RF_WE), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_ret_valid", 32'(RET_VALID), 0);
    chk("rst_fwd_hit", 32'(FWD_HIT), 0);
    check_model();
    step();
    #1;
    chk("rst_no_commit", 32'(RET_VALID), 0);
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      set_idle();
      RST       = ($urandom_range(0, 59) == 0);
      RF_READY  = ($urandom_range(0, 9) < 7);
      FWD_RADDR = 4'($urandom_range(0, 5));
      if (model_ready()) begin
        MEM_VALID = ($urandom_range(0, 1) == 1);
        ALU_VALID = ($urandom_range(0, 1) == 1);
      end
      MEM_ADDR = 4'($urandom_range(0, 5));
      ALU_ADDR = 4'($urandom_range(0, 5));
      MEM_DATA = 16'($urandom);
      ALU_DATA = 16'($urandom);
      #1;
      check_model();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
